// File: rtl/seq_ctrl.sv
// Stage sequencer: launches NUM_STAGES sub-operations strictly in order, advancing on each
// stage's completion pulse, with an optional per-stage timeout and an abort that always wins.
module seq_ctrl #(
  parameter int unsigned            NUM_STAGES    = 6,
  parameter logic [NUM_STAGES-1:0]  DONE_REG_MASK = {NUM_STAGES{1'b0}},
  parameter int unsigned            TIMEOUT_CYC   = 0,
  parameter int unsigned            CNT_W         = 24,
  localparam int unsigned           SW            = $clog2(NUM_STAGES + 2)
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [SW-1:0]         status
);

  typedef enum logic [1:0] {StIdle, StRun, StError} state_e;

  localparam logic [SW-1:0]    LastIdx    = SW'(NUM_STAGES - 1);
  localparam logic [SW-1:0]    ErrCode    = SW'(NUM_STAGES + 1);
  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYC);
  localparam bit               TimeoutEn  = (TIMEOUT_CYC != 0);

  state_e                  state_q, state_d;
  logic [SW-1:0]           idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_STAGES-1:0]   dly_q, dly_d;
  logic [NUM_STAGES-1:0]   stage_start_q, stage_start_d;
  logic                    done_q, done_d;
  logic [NUM_STAGES-1:0]   eff_done;
  logic                    ed_cur;
  logic                    launch;

  // Masked stages see their completion pulse one cycle late through dly_q.
  assign dly_d    = abort ? '0 : (stage_done & DONE_REG_MASK);
  assign eff_done = (stage_done & ~DONE_REG_MASK) | (dly_q & DONE_REG_MASK);

  // Only the active stage's completion matters; all others are ignored.
  always_comb begin
    ed_cur = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (idx_q == SW'(k)) begin
        ed_cur = eff_done[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    launch  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start) begin
          state_d = StRun;
          idx_d   = '0;
          launch  = 1'b1;
        end
      end
      StRun: begin
        // Completion takes precedence over a timeout on the same edge.
        if (ed_cur) begin
          cnt_d = '0;
          if (idx_q == LastIdx) begin
            state_d = StIdle;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_q + SW'(1);
            launch = 1'b1;
          end
        end else if (TimeoutEn && (cnt_q == TimeoutVal)) begin
          state_d = StError;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StError: begin
        cnt_d = '0;
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    if (abort) begin
      state_d = StIdle;
      idx_d   = '0;
      cnt_d   = '0;
      launch  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_comb begin
    stage_start_d = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      stage_start_d[k] = launch && (idx_d == SW'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      cnt_q         <= '0;
      dly_q         <= '0;
      stage_start_q <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      dly_q         <= dly_d;
      stage_start_q <= stage_start_d;
      done_q        <= done_d;
    end
  end

  assign stage_start = stage_start_q;
  assign done        = done_q;
  assign busy        = (state_q == StRun);
  assign error       = (state_q == StError);

  always_comb begin
    status = '0;
    case (state_q)
      StRun:   status = idx_q + SW'(1);
      StError: status = ErrCode;
      default: status = '0;
    endcase
  end

endmodule

// File: tb/tb_seq_ctrl.sv
// Scoreboard bench for seq_ctrl: stimulus queues expected output events, a negedge monitor
// pops and compares every stage_start / done / error-entry event the DUT presents.
module tb_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [5:0] stage_done = '0;
  logic [5:0] stage_start;
  logic       busy;
  logic       done;
  logic       error;
  logic [2:0] status;

  seq_ctrl #(
    .NUM_STAGES   (6),
    .DONE_REG_MASK(6'b000100),
    .TIMEOUT_CYC  (10),
    .CNT_W        (24)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .start      (start),
    .abort      (abort),
    .stage_done (stage_done),
    .stage_start(stage_start),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .status     (status)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [5:0] ss;
    logic       dn;
    logic       bz;
    logic       er;
    logic [2:0] st;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   base = 0;
  logic err_prev = 1'b0;

  // Hand-computed launch offsets from the start edge: 5 cycles per stage, +1 for masked stage 2.
  int launch_off[6] = '{0, 5, 10, 16, 21, 26};
  localparam int DoneOff = 31;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_b && (stage_start != 6'b0 || done || (error && !err_prev))) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event @%0d: got ss=%b done=%b busy=%b err=%b st=%0d, want none",
                 cyc, stage_start, done, busy, error, status);
      end else begin
        mon_e = exp_q.pop_front();
        if (cyc != mon_e.cyc || stage_start != mon_e.ss || done != mon_e.dn ||
            busy != mon_e.bz || error != mon_e.er || status != mon_e.st) begin
          bad++;
          $display("FAIL event: got @%0d ss=%b done=%b busy=%b err=%b st=%0d, want @%0d ss=%b done=%b busy=%b err=%b st=%0d",
                   cyc, stage_start, done, busy, error, status,
                   mon_e.cyc, mon_e.ss, mon_e.dn, mon_e.bz, mon_e.er, mon_e.st);
        end
      end
    end
    err_prev = error;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  task automatic push_launch(input int c, input int k);
    exp_t e;
    e.cyc = c; e.ss = 6'(1 << k); e.dn = 1'b0; e.bz = 1'b1; e.er = 1'b0; e.st = 3'(k + 1);
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int c);
    exp_t e;
    e.cyc = c; e.ss = 6'b0; e.dn = 1'b1; e.bz = 1'b0; e.er = 1'b0; e.st = 3'd0;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input int c);
    exp_t e;
    e.cyc = c; e.ss = 6'b0; e.dn = 1'b0; e.bz = 1'b0; e.er = 1'b1; e.st = 3'd7;
    exp_q.push_back(e);
  endtask

  task automatic drain_chk(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: pending expected events %0d, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Start a sequence, answer the first n_done stages 5 cycles after their launch.
  task automatic launch_and_run(input int n_done, input int n_launch, input bit hold);
    base = cyc + 1;
    for (int k = 0; k < n_launch; k++) push_launch(base + launch_off[k], k);
    if (n_done == 6) push_done(base + DoneOff);
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    for (int k = 0; k < n_done; k++) begin
      wait_cyc(base + launch_off[k] + 4);
      stage_done[k] = 1'b1;
      tick();
      stage_done = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_stage_start", 32'(stage_start), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    chk("rst_status", 32'(status), 32'h0);
    rst_b = 1'b1;
    repeat (2) tick();
    chk("idle_status", 32'(status), 32'h0);

    // Full sequence with one registered-done stage
    launch_and_run(6, 6, 1'b0);
    repeat (3) tick();
    chk("after_done_status", 32'(status), 32'h0);
    drain_chk("full_run");

    // Stray done, start mid-run, then abort racing stage_done[3]
    launch_and_run(1, 2, 1'b0);
    wait_cyc(base + 6);
    stage_done[4] = 1'b1;
    tick();
    stage_done = '0;
    chk("stray_done_status", 32'(status), 32'h2);
    wait_cyc(base + 9);
    push_launch(base + 10, 2);
    stage_done[1] = 1'b1;
    tick();
    stage_done = '0;
    wait_cyc(base + 11);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_run_status", 32'(status), 32'h3);
    wait_cyc(base + 14);
    push_launch(base + 16, 3);
    stage_done[2] = 1'b1;
    tick();
    stage_done = '0;
    wait_cyc(base + 18);
    abort = 1'b1;
    stage_done[3] = 1'b1;
    tick();
    abort = 1'b0;
    stage_done = '0;
    chk("abort_status", 32'(status), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_stage_start", 32'(stage_start), 32'h0);
    repeat (3) tick();
    drain_chk("stray_abort");

    // Done on the timeout edge advances; then stage 1 times out
    base = cyc + 1;
    push_launch(base, 0);
    push_launch(base + 11, 1);
    push_err(base + 22);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_cyc(base + 10);
    stage_done[0] = 1'b1;
    tick();
    stage_done = '0;
    wait_cyc(base + 23);
    chk("timeout_error", 32'(error), 32'h1);
    chk("timeout_status", 32'(status), 32'h7);
    start = 1'b1;
    stage_done = 6'h3f;
    repeat (3) tick();
    stage_done = '0;
    chk("error_hold_status", 32'(status), 32'h7);
    chk("error_hold_busy", 32'(busy), 32'h0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    chk("err_abort_status", 32'(status), 32'h0);
    chk("err_abort_error", 32'(error), 32'h0);
    tick();
    chk("err_abort_idle", 32'(status), 32'h0);
    drain_chk("timeout");

    // Start held across done relaunches back-to-back
    launch_and_run(6, 6, 1'b1);
    push_launch(base + DoneOff + 1, 0);
    tick();
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (2) tick();
    chk("b2b_abort_status", 32'(status), 32'h0);
    drain_chk("back_to_back");

    // Asynchronous reset in RUN(2) while stage_start[2] is high
    launch_and_run(2, 2, 1'b0);
    chk("pre_rst_status", 32'(status), 32'h3);
    chk("pre_rst_stage_start", 32'(stage_start), 32'h4);
    #1 rst_b = 1'b0;
    #1;
    chk("async_rst_stage_start", 32'(stage_start), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_status", 32'(status), 32'h0);
    tick();
    rst_b = 1'b1;
    repeat (4) tick();
    chk("post_rst_status", 32'(status), 32'h0);
    chk("post_rst_busy", 32'(busy), 32'h0);
    drain_chk("reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_ctrl.md
SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 Parameter NUM_STAGES, default 6, number of sequenced sub-operations (2..16).
REQ-002 Parameter DONE_REG_MASK, default {NUM_STAGES{1'b0}}; bit k=1 means stage_done[k] passes through one register before use.
REQ-003 Parameter TIMEOUT_CYC, default 0, max cycles per stage before error; 0 disables timeout.
REQ-004 Parameter CNT_W, default 24, width of the per-stage cycle counter; TIMEOUT_CYC SHALL fit in CNT_W bits.
REQ-005 Local SW = clog2(NUM_STAGES+2), status width.
REQ-006 clk  input  1  single system clock, all logic on rising edge.
REQ-007 rst_b  input  1  asynchronous active-low reset.
REQ-008 start  input  1  level; sampled in IDLE to launch a sequence.
REQ-009 abort  input  1  level; forces return to IDLE from any state.
REQ-010 stage_done  input  NUM_STAGES  per-stage completion pulses from sub-blocks.
REQ-011 stage_start  output  NUM_STAGES  one-hot single-cycle launch pulses, registered.
REQ-012 busy  output  1  high in any RUN state.
REQ-013 done  output  1  single-cycle pulse after last stage completes.
REQ-014 error  output  1  high while in ERROR state.
REQ-015 status  output  SW  0=IDLE, k+1=running stage k, NUM_STAGES+1=ERROR.

Function
REQ-016 States: IDLE, RUN(k) for k=0..NUM_STAGES-1, ERROR; state held in a registered index.
REQ-017 IDLE, start=1 at edge t: state RUN(0) and stage_start[0]=1 during cycle t+1 only.
REQ-018 Effective done edk = stage_done[k] if DONE_REG_MASK[k]=0, else stage_done[k] delayed one cycle.
REQ-019 RUN(k), edk=1 at edge t, k<NUM_STAGES-1: state RUN(k+1), stage_start[k+1]=1 during cycle t+1 only.
REQ-020 RUN(NUM_STAGES-1), edk=1 at edge t: state IDLE, done=1 during cycle t+1 only.
REQ-021 In RUN(k), effective done of any stage j!=k SHALL be ignored.
REQ-022 start SHALL be ignored outside IDLE; start held high after done launches a new sequence on the next edge (back-to-back).
REQ-023 Cycle counter clears to 0 on every stage transition, increments each RUN cycle, saturates at all-ones.
REQ-024 TIMEOUT_CYC>0, counter==TIMEOUT_CYC and edk=0: state ERROR next edge, no stage_start, no done.
REQ-025 Same-edge edk=1 and timeout: done wins, normal advance.
REQ-026 ERROR holds, ignoring start and stage_done, until abort.
REQ-027 abort=1 at any edge: state IDLE next cycle, no stage_start, no done, counter and done-delay registers cleared; abort has priority over start, done and timeout.
REQ-028 stage_start is at most one-hot in any cycle; never asserted in IDLE or ERROR.
REQ-029 busy and status are decoded combinationally from the state register only.

Reset
REQ-030 rst_b=0 asynchronously forces IDLE, stage_start=0, done=0, error=0, busy=0, status=0, counter=0, done-delay registers=0.
REQ-031 Reset mid-sequence discards progress; after release the block waits in IDLE for a fresh start.
REQ-032 Outputs are stable glitch-free registers or state decodes from the first edge after rst_b rises.

Verification
REQ-033 NUM_STAGES=6, mask 0: start pulse at t0, each sub-block done 5 cycles after its stage_start -> stage_start[0..5] one-hot in order, done pulse 1 cycle after stage_done[5], status 1..6 then 0.
REQ-034 DONE_REG_MASK=6'b000100: stage_done[2] pulse -> stage_start[3] appears 2 cycles later (vs 1 for other stages).
REQ-035 TIMEOUT_CYC=10, stage 1 never done -> error=1, status=7 at cycle 11 after stage_start[1]; start ignored; abort -> status=0, error=0 next cycle.
REQ-036 Stray stage_done[4] during RUN(1), and start during RUN(2) -> no state change, no extra stage_start.
REQ-037 abort and stage_done[3] same edge in RUN(3) -> IDLE, stage_start[4] never asserted; rst_b low mid-RUN(2) -> all outputs 0 immediately.
REQ-038 start held high across done -> stage_start[0] asserted the cycle after done pulse.
